// File: rtl/router_out_arbiter_pkg.sv
// Shared types and constants for the router output-port scheduler.
package router_out_arbiter_pkg;

   localparam int NUM_PORTS     = 4;
   localparam int NUM_REQ       = NUM_PORTS;
   localparam int BYTES_PER_PKT = 4;
   localparam int PKT_W         = 8 * BYTES_PER_PKT;
   localparam int REQ_IDX_W     = $clog2(NUM_REQ);
   localparam int CNT_W         = $clog2(BYTES_PER_PKT);

   typedef struct packed {
      logic [3:0]  src;
      logic [3:0]  dest;
      logic [23:0] data;
   } pkt_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_t;

   // Wire order on the node interface: header byte first, then data MSB first.
   function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [CNT_W-1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = {p.src, p.dest};
         2'd1:    b = p.data[23:16];
         2'd2:    b = p.data[15:8];
         default: b = p.data[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// Request/packet bus from the input buffers plus the outbound node byte interface.
// master: input-buffer / node side, slave: the output-port arbiter.
interface router_out_arbiter_if;
   import router_out_arbiter_pkg::*;

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*PKT_W-1:0] pkt_in;
   logic [NUM_REQ-1:0]       ack;
   logic                     free_outbound;
   logic                     put_outbound;
   logic [7:0]               payload_outbound;
   logic                     busy;

   modport master (
      output req, pkt_in, free_outbound,
      input  ack, put_outbound, payload_outbound, busy
   );

   modport slave (
      input  req, pkt_in, free_outbound,
      output ack, put_outbound, payload_outbound, busy
   );

endinterface

// File: rtl/router_out_arbiter_rr_arbiter.sv
// Combinational rotate-priority select: the requester just after ptr_i has
// highest priority, ptr_i itself the lowest.
module rr_arbiter
   import router_out_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [REQ_IDX_W-1:0] ptr_i,
   output logic [NUM_REQ-1:0]   gnt_o,
   output logic [REQ_IDX_W-1:0] idx_o,
   output logic                 valid_o
);

   logic [REQ_IDX_W-1:0] cand;

   // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ) and keep the first hit.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = REQ_IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_out_arbiter.sv
// Output-port scheduler: round-robin grant among input buffers, then streams
// the latched packet as BYTES_PER_PKT bytes to the node.
// Optional: ROUTER_ARB_STATS_EN adds a saturating granted-packet counter (pkt_count).
//
// state | meaning
// IDLE  | waiting for free_outbound and a request; grants and latches packet
// SEND  | streaming latched packet bytes, ignores req and free_outbound
module router_out_arbiter
   import router_out_arbiter_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset_n,
   router_out_arbiter_if.slave   bus
`ifdef ROUTER_ARB_STATS_EN
   ,
   output logic [15:0]           pkt_count
`endif
);

   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_SEND = SEND;

   logic [0:0]           state_q,   state_d;
   logic [REQ_IDX_W-1:0] ptr_q,     ptr_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   pkt_t                 pkt_q,     pkt_d;
   logic [NUM_REQ-1:0]   ack_q,     ack_d;
   logic                 put_q,     put_d;
   logic [7:0]           payload_q, payload_d;

   logic [NUM_REQ-1:0]   gnt;
   logic [REQ_IDX_W-1:0] gnt_idx;
   logic                 gnt_valid;

   rr_arbiter u_rr (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .gnt_o   (gnt),
      .idx_o   (gnt_idx),
      .valid_o (gnt_valid)
   );

   // Next-state: arbitrate only in IDLE; a started packet always completes.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      pkt_d     = pkt_q;
      ack_d     = '0;
      put_d     = 1'b0;
      payload_d = 8'h00;
      case (state_q)
         ST_IDLE: begin
            if (bus.free_outbound && gnt_valid) begin
               ack_d   = gnt;
               ptr_d   = gnt_idx;
               cnt_d   = '0;
               pkt_d   = pkt_t'(bus.pkt_in[int'(gnt_idx)*PKT_W +: PKT_W]);
               state_d = ST_SEND;
            end
         end
         default: begin
            put_d     = 1'b1;
            payload_d = pkt_byte(pkt_q, cnt_q);
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BYTES_PER_PKT - 1)) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // State and registered outputs; pointer resets so port 0 wins first.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= REQ_IDX_W'(NUM_REQ - 1);
         cnt_q     <= '0;
         pkt_q     <= '0;
         ack_q     <= '0;
         put_q     <= 1'b0;
         payload_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         pkt_q     <= pkt_d;
         ack_q     <= ack_d;
         put_q     <= put_d;
         payload_q <= payload_d;
      end
   end

   assign bus.ack              = ack_q;
   assign bus.put_outbound     = put_q;
   assign bus.payload_outbound = payload_q;
   assign bus.busy             = (state_q == ST_SEND);

`ifdef ROUTER_ARB_STATS_EN
   logic [15:0] pkt_cnt_q;

   // Count grants, holding at all-ones instead of wrapping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pkt_cnt_q <= '0;
      end else if (|ack_d && (pkt_cnt_q != 16'hFFFF)) begin
         pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
   end

   assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: single packet, round-robin order,
// back-pressure, free drop mid-packet, mid-packet reset, optional stats counter.
module tb_router_out_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   router_out_arbiter_if bus ();

`ifdef ROUTER_ARB_STATS_EN
   logic [15:0] pkt_count;
`endif

   router_out_arbiter dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
`ifdef ROUTER_ARB_STATS_EN
      ,
      .pkt_count (pkt_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Waits up to 20 cycles for an ack; n is the number of falling edges waited.
   task automatic wait_ack(output logic [3:0] a, output int n);
      a = 4'b0000;
      n = 0;
      while (n < 20 && a == 4'b0000) begin
         @(negedge clk);
         n++;
         a = bus.ack;
      end
   endtask

   // Checks the next four bytes, given MSB-first as a hand-written word.
   task automatic send_check(input string tag, input logic [31:0] exp_bytes);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk({tag, "_put"}, 32'(bus.put_outbound), 32'd1);
         chk({tag, "_byte"}, 32'(bus.payload_outbound), 32'(exp_bytes[31-8*i -: 8]));
      end
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      chk({tag, "_idle_put"}, 32'(bus.put_outbound), 32'd0);
      chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   logic [3:0] a;
   int         n;
   logic [3:0] rr_ack  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [7:0] rr_byte [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};

   initial begin
      n_checks = 0;
      n_pass   = 0;
      bus.req           = '0;
      bus.pkt_in        = '0;
      bus.free_outbound = 1'b0;

      // reset values
      reset_dut();
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_put", 32'(bus.put_outbound), 32'd0);
      chk("rst_payload", 32'(bus.payload_outbound), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);

      // 1: single packet from port 0
      bus.req           = 4'b0001;
      bus.pkt_in        = {96'h0, 32'h01CADAEA};
      bus.free_outbound = 1'b1;
      rst_n             = 1'b1;
      wait_ack(a, n);
      chk("t1_ack", 32'(a), 32'b0001);
      chk("t1_lat", 32'(n), 32'd1);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      chk("t1_put_in_ack", 32'(bus.put_outbound), 32'd0);
      bus.req = 4'b0000;
      send_check("t1", 32'h01CADAEA);
      idle_check("t1");
      chk("t1_ack_clr", 32'(bus.ack), 32'd0);

      // 2: all requesting from reset -> 0,1,2,3,0 at 5-cycle spacing
      reset_dut();
      bus.req    = 4'b1111;
      bus.pkt_in = {32'h40414243, 32'h30313233, 32'h20212223, 32'h10111213};
      rst_n      = 1'b1;
      for (int g = 0; g < 5; g++) begin
         wait_ack(a, n);
         chk("t2_ack", 32'(a), 32'(rr_ack[g]));
         // one falling edge of the previous packet was spent on its first byte
         chk("t2_spacing", 32'(n), (g == 0) ? 32'd1 : 32'd4);
         if (g == 4) bus.req = 4'b0000;
         @(negedge clk);
         chk("t2_byte0", 32'(bus.payload_outbound), 32'(rr_byte[g]));
      end
      repeat (3) @(negedge clk);
      idle_check("t2");

      // 3: back-pressure holds off the grant
      bus.req           = 4'b0100;
      bus.pkt_in        = {32'h0, 32'h01CAACCA, 64'h0};
      bus.free_outbound = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("t3_hold_ack", 32'(bus.ack), 32'd0);
         chk("t3_hold_put", 32'(bus.put_outbound), 32'd0);
      end
      bus.free_outbound = 1'b1;
      wait_ack(a, n);
      chk("t3_ack", 32'(a), 32'b0100);
      chk("t3_lat", 32'(n), 32'd1);
      bus.req = 4'b0000;
      send_check("t3", 32'h01CAACCA);
      idle_check("t3");

      // 4: free_outbound dropped after the first byte does not stall the packet
      bus.req    = 4'b0001;
      bus.pkt_in = {96'h0, 32'h01CADAEA};
      wait_ack(a, n);
      chk("t4_ack", 32'(a), 32'b0001);
      bus.req = 4'b0000;
      @(negedge clk);
      chk("t4_byte0", 32'(bus.payload_outbound), 32'h01);
      bus.free_outbound = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_put", 32'(bus.put_outbound), 32'd1);
         chk("t4_byte", 32'(bus.payload_outbound), (i == 0) ? 32'hCA : (i == 1) ? 32'hDA : 32'hEA);
      end
      idle_check("t4");

      // 5: reset in the middle of a packet, then pointer back at its reset value
      bus.free_outbound = 1'b1;
      bus.req           = 4'b0001;
      wait_ack(a, n);
      chk("t5_ack", 32'(a), 32'b0001);
      bus.req = 4'b0000;
      @(negedge clk);
      chk("t5_byte0", 32'(bus.payload_outbound), 32'h01);
      @(negedge clk);
      chk("t5_byte1", 32'(bus.payload_outbound), 32'hCA);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_put", 32'(bus.put_outbound), 32'd0);
      chk("t5_rst_payload", 32'(bus.payload_outbound), 32'd0);
      chk("t5_rst_ack", 32'(bus.ack), 32'd0);
      chk("t5_rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      bus.req    = 4'b1010;
      bus.pkt_in = {32'h99887766, 32'h0, 32'h5A123456, 32'h0};
      rst_n      = 1'b1;
      wait_ack(a, n);
      chk("t5_first_gnt", 32'(a), 32'b0010);
      bus.req = 4'b0000;
      send_check("t5", 32'h5A123456);
      idle_check("t5");

      // 6: two more packets after the reset, three grants in total
      bus.req    = 4'b1000;
      bus.pkt_in = {32'h77665544, 96'h0};
      wait_ack(a, n);
      chk("t6_ack_a", 32'(a), 32'b1000);
      bus.req = 4'b0000;
      send_check("t6a", 32'h77665544);
      idle_check("t6a");
      bus.req    = 4'b0001;
      bus.pkt_in = {96'h0, 32'h12345678};
      wait_ack(a, n);
      chk("t6_ack_b", 32'(a), 32'b0001);
      bus.req = 4'b0000;
      send_check("t6b", 32'h12345678);
      idle_check("t6b");
`ifdef ROUTER_ARB_STATS_EN
      chk("t6_pkt_count", 32'(pkt_count), 32'd3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
